imem_axi_responder: RTL and testbench

AXI3 read-channel responder serving instruction words to the IF stage's instruction-cache refill path. It sits on the memory side of the AR/R link driven by the IF stage: it accepts read addresses, looks them up in an on-chip word array, and returns one data beat per request. Requests are buffered, responses are returned in order, and each response arrives after a fixed, parameterised latency. It serves as the instruction memory model for simulation and FPGA builds.

---
 rtl/axi_pkg.sv | 18 +
 rtl/imem_axi_responder_req_fifo.sv | 58 +++++
 rtl/imem_axi_responder.sv | 141 ++++++++++++++
 tb/tb_imem_axi_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI read-response codes and responder FSM encoding.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Pointer/counter width that stays legal when the range collapses to one value.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/imem_axi_responder_req_fifo.sv
// Synchronous request FIFO holding accepted-but-not-yet-serviced read requests.
module req_fifo
    import axi_pkg::*;
#(
    parameter int WIDTH = 13,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = clog2_min1(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = slots[rd_ptr];
    assign count    = cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_data;
                wr_ptr        <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/imem_axi_responder.sv
// AXI3 read-channel instruction memory: in-order, fixed-latency, one beat per request.
module imem_axi_responder
    import axi_pkg::*;
#(
    parameter int    ADDR_W          = 32,
    parameter int    DATA_W          = 32,
    parameter int    MEM_WORDS       = 4096,
    parameter int    READ_LATENCY    = 2,
    parameter int    MAX_OUTSTANDING = 2,
    parameter string INIT_FILE       = ""
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ADDR_W-1:0]                      ARADDR,
    input  logic                                   ARVALID,
    output logic                                   ARREADY,
    output logic [DATA_W-1:0]                      RDATA,
    output logic [1:0]                             RRESP,
    output logic                                   RVALID,
    input  logic                                   RREADY,
    output state_t                                 dbg_state,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   dbg_queued
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int ENT_W = IDX_W + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W = clog2_min1(READ_LATENCY);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [OUT_W-1:0]  outstanding;
    logic [IDX_W-1:0]  svc_idx;
    logic              svc_err;

    logic              ar_hs;
    logic              r_hs;
    logic [IDX_W-1:0]  ar_idx;
    logic              ar_err;
    logic [ENT_W-1:0]  ar_entry;
    logic [ENT_W-1:0]  head;
    logic [ENT_W-1:0]  next_req;
    logic              svc_start;
    logic              take_bypass;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;

    // Handshake semantics: a beat transfers on the rising edge where VALID && READY;
    // ARREADY depends on registered state only, RVALID/RDATA/RRESP hold until RREADY.
    assign ARREADY  = rst && (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign ar_hs    = ARVALID && ARREADY;
    assign r_hs     = RVALID && RREADY;

    assign ar_idx   = ARADDR[IDX_W+1:2];
    assign ar_err   = (ARADDR[1:0] != 2'b00) || ((ARADDR >> (IDX_W + 2)) != '0);
    assign ar_entry = {ar_idx, ar_err};

    // A new service begins from IDLE, or back-to-back on the R handshake.
    assign svc_start   = ((state == S_IDLE) || ((state == S_RESP) && r_hs))
                         && (ar_hs || !fifo_empty);
    assign take_bypass = svc_start && fifo_empty;
    assign next_req    = fifo_empty ? ar_entry : head;
    assign fifo_push   = ar_hs && !take_bypass && !fifo_full;
    assign fifo_pop    = svc_start && !fifo_empty;

    req_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (ar_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (dbg_queued)
    );

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            outstanding <= '0;
            svc_idx     <= '0;
            svc_err     <= 1'b0;
            RVALID      <= 1'b0;
            RDATA       <= '0;
            RRESP       <= RESP_OKAY;
        end else begin
            if (ar_hs && !r_hs) begin
                outstanding <= outstanding + 1'b1;
            end else if (r_hs && !ar_hs) begin
                outstanding <= outstanding - 1'b1;
            end

            if (svc_start) begin
                svc_idx <= next_req[ENT_W-1:1];
                svc_err <= next_req[0];
                if (READ_LATENCY == 1) begin
                    state  <= S_RESP;
                    RVALID <= 1'b1;
                    RDATA  <= next_req[0] ? '0 : mem[next_req[ENT_W-1:1]];
                    RRESP  <= next_req[0] ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    state  <= S_WAIT;
                    cnt    <= CNT_W'(READ_LATENCY - 1);
                    RVALID <= 1'b0;
                end
            end else begin
                case (state)
                    S_WAIT: begin
                        if (cnt == CNT_W'(1)) begin
                            state  <= S_RESP;
                            RVALID <= 1'b1;
                            RDATA  <= svc_err ? '0 : mem[svc_idx];
                            RRESP  <= svc_err ? RESP_SLVERR : RESP_OKAY;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_RESP: begin
                        if (r_hs) begin
                            state  <= S_IDLE;
                            RVALID <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_axi_responder.sv
// Directed bench for imem_axi_responder at default parameters (latency 2, two outstanding).
module tb_imem_axi_responder;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    state_t      dbg_state;
    logic [1:0]  dbg_queued;

    int total = 0;
    int bad   = 0;

    imem_axi_responder dut (
        .clk        (clk),
        .rst        (rst),
        .ARADDR     (ARADDR),
        .ARVALID    (ARVALID),
        .ARREADY    (ARREADY),
        .RDATA      (RDATA),
        .RRESP      (RRESP),
        .RVALID     (RVALID),
        .RREADY     (RREADY),
        .dbg_state  (dbg_state),
        .dbg_queued (dbg_queued)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        ARVALID = 1'b1;
        ARADDR  = 32'h10;
        RREADY  = 1'b1;
        dut.mem[0] = 32'h1111_0000;
        dut.mem[1] = 32'h2222_0001;
        dut.mem[2] = 32'h3333_0002;
        dut.mem[4] = 32'hDEAD_BEEF;
        dut.mem[5] = 32'h5555_0005;

        // Reset held three cycles with a pending address.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_arready", ARREADY, 32'd0);
            chk("rst_rvalid",  RVALID,  32'd0);
            chk("rst_rdata",   RDATA,   32'd0);
        end
        rst     = 1'b1;
        ARVALID = 1'b0;
        step();
        chk("post_rst_arready", ARREADY,   32'd1);
        chk("post_rst_rvalid",  RVALID,    32'd0);
        chk("post_rst_state",   dbg_state, S_IDLE);

        // Single read of mem[4].
        ARVALID = 1'b1;
        ARADDR  = 32'h10;
        RREADY  = 1'b1;
        chk("single_arready", ARREADY, 32'd1);
        step();
        ARVALID = 1'b0;
        chk("single_t1_rvalid", RVALID,    32'd0);
        chk("single_t1_state",  dbg_state, S_WAIT);
        step();
        chk("single_t2_rvalid", RVALID, 32'd1);
        chk("single_t2_rdata",  RDATA,  32'hDEAD_BEEF);
        chk("single_t2_rresp",  RRESP,  32'd0);
        step();
        chk("single_t3_rvalid", RVALID, 32'd0);

        // Backpressure: five stalled cycles then handshake.
        RREADY  = 1'b0;
        ARVALID = 1'b1;
        ARADDR  = 32'h14;
        step();
        ARVALID = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rvalid", RVALID, 32'd1);
            chk("bp_rdata",  RDATA,  32'h5555_0005);
            chk("bp_rresp",  RRESP,  32'd0);
            step();
        end
        RREADY = 1'b1;
        chk("bp_hs_rvalid", RVALID, 32'd1);
        chk("bp_hs_rdata",  RDATA,  32'h5555_0005);
        step();
        chk("bp_done_rvalid", RVALID,    32'd0);
        chk("bp_done_state",  dbg_state, S_IDLE);

        // Outstanding limit with three back-to-back addresses.
        RREADY  = 1'b0;
        ARVALID = 1'b1;
        ARADDR  = 32'h0;
        chk("ol_acc0", ARREADY, 32'd1);
        step();
        ARADDR = 32'h4;
        chk("ol_acc1", ARREADY, 32'd1);
        step();
        ARADDR = 32'h8;
        chk("ol_full_arready", ARREADY,    32'd0);
        chk("ol_full_rvalid",  RVALID,     32'd1);
        chk("ol_full_rdata0",  RDATA,      32'h1111_0000);
        chk("ol_full_queued",  dbg_queued, 32'd1);
        step();
        chk("ol_stall_arready", ARREADY, 32'd0);
        chk("ol_stall_rdata0",  RDATA,   32'h1111_0000);
        RREADY = 1'b1;
        step();
        chk("ol_reopen_arready", ARREADY, 32'd1);
        chk("ol_reopen_rvalid",  RVALID,  32'd0);
        step();
        ARVALID = 1'b0;
        chk("ol_beat1_rvalid", RVALID, 32'd1);
        chk("ol_beat1_rdata",  RDATA,  32'h2222_0001);
        step();
        chk("ol_gap_rvalid", RVALID, 32'd0);
        step();
        chk("ol_beat2_rvalid", RVALID, 32'd1);
        chk("ol_beat2_rdata",  RDATA,  32'h3333_0002);
        step();
        chk("ol_end_rvalid", RVALID, 32'd0);

        // Error responses, the second issued on the same cycle as an R handshake.
        ARVALID = 1'b1;
        ARADDR  = 32'h2;
        step();
        ARVALID = 1'b0;
        step();
        chk("err_unal_rvalid", RVALID, 32'd1);
        chk("err_unal_rresp",  RRESP,  32'd2);
        chk("err_unal_rdata",  RDATA,  32'd0);
        ARVALID = 1'b1;
        ARADDR  = 32'h4000;
        chk("err_oor_arready", ARREADY, 32'd1);
        step();
        ARVALID = 1'b0;
        chk("err_oor_wait", RVALID, 32'd0);
        step();
        chk("err_oor_rvalid", RVALID, 32'd1);
        chk("err_oor_rresp",  RRESP,  32'd2);
        chk("err_oor_rdata",  RDATA,  32'd0);
        ARVALID = 1'b1;
        ARADDR  = 32'h8;
        step();
        ARVALID = 1'b0;
        chk("err_ok_wait", RVALID, 32'd0);
        step();
        chk("err_ok_rvalid", RVALID, 32'd1);
        chk("err_ok_rresp",  RRESP,  32'd0);
        chk("err_ok_rdata",  RDATA,  32'h3333_0002);
        step();
        chk("err_end_rvalid", RVALID, 32'd0);

        // Reset while one request is in service and another queued.
        RREADY  = 1'b0;
        ARVALID = 1'b1;
        ARADDR  = 32'h0;
        step();
        ARADDR = 32'h4;
        chk("mid_wait_state", dbg_state, S_WAIT);
        step();
        ARVALID = 1'b0;
        chk("mid_resp_rvalid", RVALID,     32'd1);
        chk("mid_resp_queued", dbg_queued, 32'd1);
        rst    = 1'b0;
        RREADY = 1'b1;
        step();
        chk("mid_rst_rvalid",  RVALID,     32'd0);
        chk("mid_rst_arready", ARREADY,    32'd0);
        chk("mid_rst_queued",  dbg_queued, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("mid_quiet_rvalid", RVALID, 32'd0);
        end

        // Service resumes normally afterwards.
        ARVALID = 1'b1;
        ARADDR  = 32'h4;
        step();
        ARVALID = 1'b0;
        step();
        chk("resume_rvalid", RVALID, 32'd1);
        chk("resume_rdata",  RDATA,  32'h2222_0001);
        chk("resume_rresp",  RRESP,  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
